tff_counter: RTL and testbench

TFF_COUNTER -- requirements
Module: tff_counter

---
 rtl/tff_counter.sv | 81 ++++++++
 tb/tb_tff_counter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/tff_counter.sv
// Bank of T flip-flops that toggles per-bit, counts up or down, holds, or
// parallel-loads, with terminal-count and single-cycle wrap indication.
module tff_counter #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] T,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic             TC,
  output logic             Wrap
);

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] up_t, dn_t, t_eff;
  logic             all_ones, all_zero;

  assign mode = mode_e'(Mode);

  // Ripple-free toggle enables: bit i flips when every lower bit is 1 (up) or 0 (down).
  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_carry
    assign up_t[i] = &q_q[i-1:0];
    assign dn_t[i] = &(~q_q[i-1:0]);
  end

  assign all_ones = &q_q;
  assign all_zero = ~|q_q;

  always_comb begin
    t_eff = '0;
    if (En) begin
      unique case (mode)
        MODE_TOGGLE: t_eff = T;
        MODE_UP:     t_eff = up_t;
        MODE_DOWN:   t_eff = dn_t;
        MODE_HOLD:   t_eff = '0;
        default:     t_eff = '0;
      endcase
    end
  end

  always_comb begin
    TC     = ((mode == MODE_UP) && all_ones) || ((mode == MODE_DOWN) && all_zero);
    wrap_d = En && !Load && TC;
    q_d    = Load ? D : (q_q ^ t_eff);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the synchronous reset branch comes first to give it priority.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      q_q    <= RST_VAL;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q     = q_q;
  assign Q_bar = ~q_q;
  assign Wrap  = wrap_q;

endmodule

// File: tb/tb_tff_counter.sv
// Directed plus randomized bench for tff_counter (WIDTH=4, RST_VAL=0) against
// an arithmetic reference model of the counter.
module tb_tff_counter;

  logic       Clk = 1'b0;
  logic       Reset, En, Load;
  logic [1:0] Mode;
  logic [3:0] T, D, Q, Q_bar;
  logic       TC, Wrap;

  int checks = 0;
  int errors = 0;

  int mq;   // model value 0..15
  int mw;   // model wrap flag

  tff_counter #(.WIDTH(4), .RST_VAL(4'b0000)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Mode(Mode), .T(T),
    .Load(Load), .D(D), .Q(Q), .Q_bar(Q_bar), .TC(TC), .Wrap(Wrap)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one edge's inputs, advance the model, then compare all outputs.
  task automatic drive(input logic r, input logic l, input logic e,
                       input logic [1:0] m, input logic [3:0] t, input logic [3:0] d);
    int exp_tc;
    Reset = r; Load = l; En = e; Mode = m; T = t; D = d;
    if (r) begin
      mq = 0; mw = 0;
    end else if (l) begin
      mq = int'(d); mw = 0;
    end else if (e && m == 2'b01) begin
      mw = (mq == 15) ? 1 : 0;
      mq = (mq + 1) % 16;
    end else if (e && m == 2'b10) begin
      mw = (mq == 0) ? 1 : 0;
      mq = (mq + 15) % 16;
    end else if (e && m == 2'b00) begin
      mq = mq ^ int'(t); mw = 0;
    end else begin
      mw = 0;
    end
    @(posedge Clk);
    #1;
    exp_tc = ((m == 2'b01 && mq == 15) || (m == 2'b10 && mq == 0)) ? 1 : 0;
    check("q",     32'(Q),     32'(mq));
    check("q_bar", 32'(Q_bar), 32'(15 - mq));
    check("wrap",  32'(Wrap),  32'(mw));
    check("tc",    32'(TC),    32'(exp_tc));
  endtask

  initial begin
    logic       r, l, e;
    logic [1:0] m;
    logic [3:0] t, d;
    mq = 0; mw = 0;

    // Reset from power-up, then reset mid-count overriding En/Mode.
    drive(1, 0, 0, 2'b00, 4'h0, 4'h0);
    drive(0, 1, 0, 2'b00, 4'h0, 4'b1011);
    check("r031_pre_q", 32'(Q), 32'hb);
    drive(1, 0, 1, 2'b01, 4'h0, 4'h0);
    check("r031_q", 32'(Q), 32'h0);
    check("r031_qbar", 32'(Q_bar), 32'hf);
    check("r031_wrap", 32'(Wrap), 32'h0);

    // Toggle bank.
    drive(0, 0, 1, 2'b00, 4'b0101, 4'h0);
    check("r032_t1", 32'(Q), 32'b0101);
    drive(0, 0, 1, 2'b00, 4'b0011, 4'h0);
    check("r032_t2", 32'(Q), 32'b0110);
    drive(0, 0, 1, 2'b00, 4'b0000, 4'h0);
    check("r032_t3", 32'(Q), 32'b0110);
    drive(0, 0, 0, 2'b00, 4'b1111, 4'h0);
    check("r032_en0", 32'(Q), 32'b0110);

    // Count up through wrap.
    drive(0, 1, 0, 2'b00, 4'h0, 4'b1110);
    drive(0, 0, 1, 2'b01, 4'h0, 4'h0);
    check("r033_q15", 32'(Q), 32'hf);
    check("r033_tc", 32'(TC), 32'h1);
    check("r033_wrap0", 32'(Wrap), 32'h0);
    drive(0, 0, 1, 2'b01, 4'h0, 4'h0);
    check("r033_q0", 32'(Q), 32'h0);
    check("r033_wrap1", 32'(Wrap), 32'h1);
    drive(0, 0, 1, 2'b01, 4'h0, 4'h0);
    check("r033_q1", 32'(Q), 32'h1);
    check("r033_wrap_clr", 32'(Wrap), 32'h0);

    // Count down through wrap.
    drive(0, 1, 0, 2'b00, 4'h0, 4'b0001);
    drive(0, 0, 1, 2'b10, 4'h0, 4'h0);
    check("r034_q0", 32'(Q), 32'h0);
    check("r034_tc", 32'(TC), 32'h1);
    drive(0, 0, 1, 2'b10, 4'h0, 4'h0);
    check("r034_q15", 32'(Q), 32'hf);
    check("r034_wrap1", 32'(Wrap), 32'h1);
    drive(0, 0, 1, 2'b10, 4'h0, 4'h0);
    check("r034_q14", 32'(Q), 32'he);
    check("r034_wrap_clr", 32'(Wrap), 32'h0);

    // Load beats count; reset beats load.
    drive(0, 1, 1, 2'b01, 4'h0, 4'b1010);
    check("r035_load", 32'(Q), 32'ha);
    drive(1, 1, 1, 2'b01, 4'h0, 4'b1010);
    check("r035_rst", 32'(Q), 32'h0);

    // Hold mode ignores En.
    drive(0, 1, 0, 2'b00, 4'h0, 4'b0111);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 2'b11, 4'hf, 4'h0);
    check("r036_q", 32'(Q), 32'h7);
    check("r036_wrap", 32'(Wrap), 32'h0);
    check("r036_tc", 32'(TC), 32'h0);

    // Randomized traffic, weighted toward counting so wraps occur often.
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 29) == 0);
      l = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 3) != 0);
      m = 2'($urandom);
      t = 4'($urandom);
      d = 4'($urandom);
      drive(r, l, e, m, t, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
